// File: rtl/conv_window_feeder.sv
// Streaming KX x KY sliding-window generator feeding the layer-1 channel_accumulator.
// Accepts one CI-channel pixel per cycle in raster order and emits one packed window
// per valid stride-1, no-padding convolution position.
module conv_window_feeder #(
  parameter int I_F_BW = 8,
  parameter int CI     = 1,
  parameter int KX     = 5,
  parameter int KY     = 5,
  parameter int IW     = 28,
  parameter int IH     = 28
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [CI*I_F_BW-1:0]         in_pixel,
  output logic                         in_ready,
  output logic                         data_valid,
  output logic [CI*KX*KY*I_F_BW-1:0]   feature_map,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int FMW = CI*KX*KY*I_F_BW;
  localparam int CW  = (IW > 1) ? $clog2(IW) : 1;
  localparam int RW  = (IH > 1) ? $clog2(IH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IW-1);
  localparam logic [CW-1:0] COL_MIN  = CW'(KX-1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IH-1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(KY-1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              data_valid_q, data_valid_d;
  logic [FMW-1:0]    feature_map_q, feature_map_d;

  logic [I_F_BW-1:0] lb_q   [CI][KY-1][IW];
  logic [I_F_BW-1:0] win_q  [CI][KY][KX];
  logic [I_F_BW-1:0] win_d  [CI][KY][KX];
  logic [I_F_BW-1:0] newcol [CI][KY];

  logic accept;
  logic win_ok;

  // in_ready_q mirrors state_q == S_STREAM, so this is the handshake
  assign accept = in_valid && in_ready_q;

  // FSM next state and raster counters
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_STREAM;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_STREAM: begin
        if (accept) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) state_d = S_DONE;
            else                   row_d   = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    in_ready_d   = (state_d == S_STREAM);
    busy_d       = (state_d != S_IDLE);
    // Registered off the DONE state so the pulse lands the cycle after the last window
    frame_done_d = (state_q == S_DONE);
  end

  // New window column from the line buffer plus incoming pixel, then shift window left
  always_comb begin
    for (int unsigned ch = 0; ch < CI; ch++) begin
      for (int unsigned ky = 0; ky < KY-1; ky++) newcol[ch][ky] = lb_q[ch][ky][col_q];
      newcol[ch][KY-1] = in_pixel[ch*I_F_BW +: I_F_BW];
    end
    win_d = win_q;
    if (accept) begin
      for (int unsigned ch = 0; ch < CI; ch++) begin
        for (int unsigned ky = 0; ky < KY; ky++) begin
          for (int unsigned kx = 0; kx < KX-1; kx++) win_d[ch][ky][kx] = win_q[ch][ky][kx+1];
          win_d[ch][ky][KX-1] = newcol[ch][ky];
        end
      end
    end
  end

  // Window emission: valid only once a full KY x KX neighbourhood lies inside the current rows
  always_comb begin
    win_ok        = accept && (row_q >= ROW_MIN) && (col_q >= COL_MIN);
    data_valid_d  = win_ok;
    feature_map_d = feature_map_q;
    if (win_ok) begin
      for (int unsigned ch = 0; ch < CI; ch++)
        for (int unsigned ky = 0; ky < KY; ky++)
          for (int unsigned kx = 0; kx < KX; kx++)
            feature_map_d[((ch*KY + ky)*KX + kx)*I_F_BW +: I_F_BW] = win_d[ch][ky][kx];
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      data_valid_q  <= 1'b0;
      feature_map_q <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      data_valid_q  <= data_valid_d;
      feature_map_q <= feature_map_d;
    end
  end

  // Line buffer and window storage; unreset, stale rows are always rewritten before use
  always_ff @(posedge clk) begin
    win_q <= win_d;
    if (accept) begin
      for (int unsigned ch = 0; ch < CI; ch++)
        for (int unsigned r = 0; r < KY-1; r++)
          lb_q[ch][r][col_q] <= newcol[ch][r+1];
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign data_valid  = data_valid_q;
  assign feature_map = feature_map_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench for conv_window_feeder: frame-level reference model built from
// an image array, checked every cycle against data_valid/feature_map/control outputs.
module tb_conv_window_feeder;

  localparam int BW  = 8;
  localparam int KX  = 5;
  localparam int KY  = 5;
  localparam int IW  = 28;
  localparam int IH  = 28;
  localparam int FMW = KX*KY*BW;
  localparam int NWIN = (IW-KX+1)*(IH-KY+1);
  localparam int IW2 = 10;
  localparam int IH2 = 8;
  localparam int NWIN2 = (IW2-KX+1)*(IH2-KY+1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic            start = 1'b0, in_valid = 1'b0;
  logic [BW-1:0]   in_pixel = '0;
  logic            in_ready, data_valid, busy, frame_done;
  logic [FMW-1:0]  feature_map;

  logic              start2 = 1'b0, in_valid2 = 1'b0;
  logic [2*BW-1:0]   in_pixel2 = '0;
  logic              in_ready2, data_valid2, busy2, frame_done2;
  logic [2*FMW-1:0]  feature_map2;

  conv_window_feeder #(.I_F_BW(BW), .CI(1), .KX(KX), .KY(KY), .IW(IW), .IH(IH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_pixel(in_pixel),
    .in_ready(in_ready), .data_valid(data_valid), .feature_map(feature_map),
    .busy(busy), .frame_done(frame_done));

  conv_window_feeder #(.I_F_BW(BW), .CI(2), .KX(KX), .KY(KY), .IW(IW2), .IH(IH2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .in_valid(in_valid2), .in_pixel(in_pixel2),
    .in_ready(in_ready2), .data_valid(data_valid2), .feature_map(feature_map2),
    .busy(busy2), .frame_done(frame_done2));

  int tests = 0;
  int failed = 0;

  logic [BW-1:0]  img  [IH][IW];
  logic [BW-1:0]  img2 [IH2][IW2];
  logic [FMW-1:0] exp_hold = '0;
  logic [FMW-1:0] obs_first, obs_25, obs_last;
  int             win_cnt;

  function automatic logic [FMW-1:0] model_win(input int r, input int c);
    logic [FMW-1:0] w;
    w = '0;
    for (int ky = 0; ky < KY; ky++)
      for (int kx = 0; kx < KX; kx++)
        w[(ky*KX+kx)*BW +: BW] = img[r-KY+1+ky][c-KX+1+kx];
    return w;
  endfunction

  // mode: 0 ramp, 1 const 0x55, 2 const 0xAA, 3 random pixels
  task automatic run_frame(input int mode, input int gap_pct, input int abort_row, input int start_row);
    int r, c, cyc;
    bit acc, exp_dv;
    logic [FMW-1:0] exp_fm;
    for (int i = 0; i < IH; i++)
      for (int j = 0; j < IW; j++)
        case (mode)
          0:       img[i][j] = BW'((i*IW + j) % 256);
          1:       img[i][j] = 8'h55;
          2:       img[i][j] = 8'hAA;
          default: img[i][j] = BW'($urandom_range(255));
        endcase
    r = 0; c = 0; cyc = 0; win_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      failed++; $display("FAIL frame_start: busy=%0b in_ready=%0b want 1 1", busy, in_ready);
    end
    while (r < IH) begin
      if (r == abort_row) break;
      if (cyc > 20000) begin
        tests++; failed++; $display("FAIL frame_timeout: row=%0d col=%0d", r, c);
        break;
      end
      in_valid = ($urandom_range(99) >= gap_pct);
      in_pixel = img[r][c];
      start    = (r == start_row && c == 0);
      tests++;
      if (in_ready !== 1'b1) begin
        failed++; $display("FAIL in_ready_stream: got %0b want 1 at (%0d,%0d)", in_ready, r, c);
      end
      acc = in_valid;
      @(negedge clk); cyc++;
      start = 1'b0;
      exp_dv = acc && r >= KY-1 && c >= KX-1;
      tests++;
      if (data_valid !== exp_dv) begin
        failed++; $display("FAIL data_valid: got %0b want %0b after (%0d,%0d)", data_valid, exp_dv, r, c);
      end
      if (exp_dv) begin
        exp_fm = model_win(r, c);
        exp_hold = exp_fm;
        if (win_cnt == 0)  obs_first = feature_map;
        if (win_cnt == 24) obs_25 = feature_map;
        obs_last = feature_map;
        win_cnt++;
      end
      tests++;
      if (feature_map !== exp_hold) begin
        failed++; $display("FAIL feature_map: got %h want %h after (%0d,%0d)", feature_map, exp_hold, r, c);
      end
      if (acc) begin
        if (c == IW-1) begin c = 0; r++; end
        else c++;
      end
    end
    in_valid = 1'b0;
    if (r == IH) begin
      tests++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0) begin
        failed++; $display("FAIL last_window_ctrl: in_ready=%0b busy=%0b frame_done=%0b want 0 1 0",
                           in_ready, busy, frame_done);
      end
      @(negedge clk);
      tests++;
      if (frame_done !== 1'b1 || busy !== 1'b0 || data_valid !== 1'b0) begin
        failed++; $display("FAIL frame_done_pulse: frame_done=%0b busy=%0b dv=%0b want 1 0 0",
                           frame_done, busy, data_valid);
      end
      @(negedge clk);
      tests++;
      if (frame_done !== 1'b0) begin
        failed++; $display("FAIL frame_done_width: got %0b want 0", frame_done);
      end
      tests++;
      if (win_cnt != NWIN) begin
        failed++; $display("FAIL window_count: got %0d want %0d", win_cnt, NWIN);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || data_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 ||
        feature_map !== '0) begin
      failed++; $display("FAIL reset_state: rdy=%0b dv=%0b busy=%0b fd=%0b fm=%h want all 0",
                         in_ready, data_valid, busy, frame_done, feature_map);
    end
    reset_n = 1'b1;
    exp_hold = '0;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    int last_el0;
    run_frame(0, 0, -1, -1);
    last_el0 = ((IH-KY)*IW + (IW-KX)) % 256;
    tests++;
    if (obs_first[0 +: BW] !== 8'd0 || obs_first[24*BW +: BW] !== 8'd116) begin
      failed++; $display("FAIL ramp_first: el0=%0d el24=%0d want 0 116",
                         obs_first[0 +: BW], obs_first[24*BW +: BW]);
    end
    tests++;
    if (obs_25[0 +: BW] !== 8'd28 || obs_25[24*BW +: BW] !== 8'd144) begin
      failed++; $display("FAIL row_boundary: el0=%0d el24=%0d want 28 144",
                         obs_25[0 +: BW], obs_25[24*BW +: BW]);
    end
    tests++;
    if (obs_last[0 +: BW] !== BW'(last_el0)) begin
      failed++; $display("FAIL ramp_last: el0=%0d want %0d", obs_last[0 +: BW], last_el0);
    end
  endtask

  // 50% gaps with a stray start pulse mid-frame; the model is gap-independent
  task automatic test_gaps();
    run_frame(0, 50, -1, 10);
  endtask

  task automatic test_idle_valid();
    in_valid = 1'b1;
    in_pixel = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b0 || data_valid !== 1'b0 || busy !== 1'b0 || feature_map !== exp_hold) begin
        failed++; $display("FAIL idle_valid: rdy=%0b dv=%0b busy=%0b fm=%h want 0 0 0 %h",
                           in_ready, data_valid, busy, feature_map, exp_hold);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_const55();
    run_frame(1, 0, -1, -1);
  endtask

  task automatic test_random();
    run_frame(3, 30, -1, -1);
  endtask

  task automatic test_reset_mid();
    run_frame(0, 0, 10, -1);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || data_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 ||
        feature_map !== '0) begin
      failed++; $display("FAIL reset_mid: rdy=%0b dv=%0b busy=%0b fd=%0b fm=%h want all 0",
                         in_ready, data_valid, busy, frame_done, feature_map);
    end
    reset_n = 1'b1;
    exp_hold = '0;
    run_frame(2, 0, -1, -1);
  endtask

  task automatic test_multichannel();
    int cnt, cyc;
    bit exp_dv;
    logic [FMW-1:0] w0, w1;
    for (int i = 0; i < IH2; i++)
      for (int j = 0; j < IW2; j++) img2[i][j] = BW'($urandom_range(255));
    cnt = 0; cyc = 0;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int r = 0; r < IH2; r++) begin
      for (int c = 0; c < IW2; c++) begin
        in_valid2 = 1'b1;
        in_pixel2 = {img2[r][c] + 8'd1, img2[r][c]};
        @(negedge clk); cyc++;
        exp_dv = r >= KY-1 && c >= KX-1;
        tests++;
        if (data_valid2 !== exp_dv) begin
          failed++; $display("FAIL ci2_valid: got %0b want %0b after (%0d,%0d)", data_valid2, exp_dv, r, c);
        end
        if (exp_dv) begin
          for (int ky = 0; ky < KY; ky++)
            for (int kx = 0; kx < KX; kx++) begin
              w0[(ky*KX+kx)*BW +: BW] = img2[r-KY+1+ky][c-KX+1+kx];
              w1[(ky*KX+kx)*BW +: BW] = img2[r-KY+1+ky][c-KX+1+kx] + 8'd1;
            end
          cnt++;
          tests++;
          if (feature_map2 !== {w1, w0}) begin
            failed++; $display("FAIL ci2_window: got %h want %h at (%0d,%0d)", feature_map2, {w1, w0}, r, c);
          end
        end
      end
    end
    in_valid2 = 1'b0;
    @(negedge clk); @(negedge clk);
    tests++;
    if (cnt != NWIN2 || busy2 !== 1'b0) begin
      failed++; $display("FAIL ci2_done: windows=%0d busy=%0b want %0d 0", cnt, busy2, NWIN2);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_gaps();
    test_idle_valid();
    test_const55();
    test_random();
    test_reset_mid();
    test_multichannel();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
